// File: rtl/multiline_block_reader.sv
// rtl/multiline_block_reader.sv - reassembles BUF_AMOUNT line streams into BLOCK_W x BUF_AMOUNT raster blocks
// Optional output register: define MULTILINE_BLOCK_READER_OUT_REG_EN.
module multiline_block_reader #(
    parameter int BUF_AMOUNT  = 8,
    parameter int BLOCK_W     = 8,
    parameter int PX_WIDTH    = 8,
    parameter int FRAME_RES_X = 1280,
    localparam int TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [BUF_AMOUNT-1:0][TDATA_WIDTH-1:0]  video_tdata_i,
    input  logic [BUF_AMOUNT-1:0]                   video_tvalid_i,
    output logic [BUF_AMOUNT-1:0]                   video_tready_o,
    input  logic [BUF_AMOUNT-1:0]                   video_tlast_i,
    input  logic [BUF_AMOUNT-1:0]                   video_tuser_i,
    output logic [TDATA_WIDTH-1:0]                  block_tdata_o,
    output logic                                    block_tvalid_o,
    input  logic                                    block_tready_i,
    output logic                                    block_tlast_o,
    output logic                                    block_tuser_o,
    output logic [TDATA_WIDTH/8-1:0]                block_tstrb_o,
    output logic [TDATA_WIDTH/8-1:0]                block_tkeep_o,
    output logic                                    block_tid_o,
    output logic                                    block_tdest_o,
    output logic                                    err_o
);
    localparam int BLK_N = FRAME_RES_X / BLOCK_W;
    localparam int COL_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int ROW_W = (BUF_AMOUNT > 1) ? $clog2(BUF_AMOUNT) : 1;
    localparam int BLK_W = (BLK_N > 1) ? $clog2(BLK_N) : 1;

    logic [COL_W-1:0]       col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]       row_cnt_q, row_cnt_d;
    logic [BLK_W-1:0]       blk_cnt_q, blk_cnt_d;
    logic                   err_q, err_d;
    logic                   sel_valid, sel_last, sel_user, in_ready, accept;
    logic [TDATA_WIDTH-1:0] sel_data;
    logic                   col_end, row_end, blk_end, exp_last, blk_origin;

    always_comb begin
        sel_valid  = video_tvalid_i[row_cnt_q];
        sel_data   = video_tdata_i[row_cnt_q];
        sel_last   = video_tlast_i[row_cnt_q];
        sel_user   = video_tuser_i[row_cnt_q];
        col_end    = (col_cnt_q == COL_W'(BLOCK_W - 1));
        row_end    = (row_cnt_q == ROW_W'(BUF_AMOUNT - 1));
        blk_end    = (blk_cnt_q == BLK_W'(BLK_N - 1));
        exp_last   = blk_end && col_end;
        blk_origin = (col_cnt_q == '0) && (row_cnt_q == '0) && (blk_cnt_q == '0);
        accept     = sel_valid && in_ready && !rst_i;

        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        blk_cnt_d = blk_cnt_q;
        err_d     = err_q;
        if (accept) begin
            if (col_end) begin
                col_cnt_d = '0;
                if (row_end) begin
                    row_cnt_d = '0;
                    blk_cnt_d = blk_end ? '0 : blk_cnt_q + 1'b1;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
            // Line tlast only lines up with the counters at the stripe's last column.
            if ((sel_last != exp_last) || (sel_user && !blk_origin)) begin
                err_d = 1'b1;
            end
        end

        video_tready_o            = '0;
        video_tready_o[row_cnt_q] = in_ready && !rst_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            blk_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            blk_cnt_q <= blk_cnt_d;
            err_q     <= err_d;
        end
    end

`ifdef MULTILINE_BLOCK_READER_OUT_REG_EN
    logic                   out_valid_q;
    logic [TDATA_WIDTH-1:0] out_data_q;
    logic                   out_last_q, out_user_q;

    assign in_ready = !out_valid_q || block_tready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= col_end && row_end;
            out_user_q  <= sel_user;
        end else if (block_tready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign block_tvalid_o = out_valid_q;
    assign block_tdata_o  = out_data_q;
    assign block_tlast_o  = out_last_q;
    assign block_tuser_o  = out_user_q;
`else
    assign in_ready       = block_tready_i;
    assign block_tvalid_o = sel_valid && !rst_i;
    assign block_tdata_o  = sel_data;
    assign block_tlast_o  = col_end && row_end;
    assign block_tuser_o  = sel_user;
`endif

    assign block_tstrb_o = '1;
    assign block_tkeep_o = '1;
    assign block_tid_o   = 1'b0;
    assign block_tdest_o = 1'b0;
    assign err_o         = err_q;

endmodule

// File: tb/tb_multiline_block_reader.sv
// tb/tb_multiline_block_reader.sv - scoreboard bench for multiline_block_reader
module tb_multiline_block_reader;
    localparam int BUF  = 8;
    localparam int BW   = 8;
    localparam int FRX  = 16;
    localparam int TDW  = 8;
    localparam int NPIX = BUF * FRX;
`ifdef MULTILINE_BLOCK_READER_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic                      clk_i = 1'b0;
    logic                      rst_i = 1'b1;
    logic [BUF-1:0][TDW-1:0]   video_tdata = '0;
    logic [BUF-1:0]            video_tvalid = '0;
    logic [BUF-1:0]            video_tready;
    logic [BUF-1:0]            video_tlast = '0;
    logic [BUF-1:0]            video_tuser = '0;
    logic [TDW-1:0]            block_tdata;
    logic                      block_tvalid;
    logic                      block_tready = 1'b0;
    logic                      block_tlast, block_tuser;
    logic [0:0]                block_tstrb, block_tkeep;
    logic                      block_tid, block_tdest;
    logic                      err_o;

    int         errors = 0;
    int         checks = 0;
    int         mode = 0;
    int         x [BUF];
    bit         err_model = 1'b0;
    logic [9:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    multiline_block_reader #(
        .BUF_AMOUNT(BUF), .BLOCK_W(BW), .PX_WIDTH(8), .FRAME_RES_X(FRX)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .video_tdata_i(video_tdata), .video_tvalid_i(video_tvalid),
        .video_tready_o(video_tready), .video_tlast_i(video_tlast),
        .video_tuser_i(video_tuser),
        .block_tdata_o(block_tdata), .block_tvalid_o(block_tvalid),
        .block_tready_i(block_tready), .block_tlast_o(block_tlast),
        .block_tuser_o(block_tuser), .block_tstrb_o(block_tstrb),
        .block_tkeep_o(block_tkeep), .block_tid_o(block_tid),
        .block_tdest_o(block_tdest), .err_o(err_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit user_fn(input int m, input int n, input int px);
        return (m == 2) && (((n == 0) && (px == 0)) || ((n == 3) && (px == 5)));
    endfunction

    function automatic bit last_fn(input int m, input int n, input int px);
        if ((m == 3) && (n == 2)) return px == 7;
        return px == FRX - 1;
    endfunction

    task automatic drive_line(input int n);
        video_tdata[n] = TDW'(n * 16 + x[n]);
        video_tlast[n] = last_fn(mode, n, x[n]);
        video_tuser[n] = user_fn(mode, n, x[n]);
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        block_tready = 1'b1;
        err_model    = 1'b0;
        exp_q.delete();
        for (int n = 0; n < BUF; n++) begin
            x[n] = 0;
            video_tvalid[n] = 1'b1;
            drive_line(n);
        end
        repeat (3) begin
            @(negedge clk_i);
            check("rst_tvalid", int'(block_tvalid), 0);
            check("rst_tready", int'(video_tready), 0);
            check("rst_err", int'(err_o), 0);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // Expected output order is the block-raster walk of the stripe, independent of input timing.
    task automatic run_stripe(input int m, input int rst_after);
        int in_cnt = 0, out_cnt = 0, last_cnt = 0;
        int first_in = -1, first_out = -1, last_out = -1;
        bit hs [BUF];
        bit done = 1'b0;
        logic [9:0] e;
        mode = m;
        do_reset();
        for (int b = 0; b < FRX / BW; b++)
            for (int r = 0; r < BUF; r++)
                for (int c = 0; c < BW; c++)
                    exp_q.push_back({8'(r * 16 + b * BW + c), (r == BUF - 1) && (c == BW - 1),
                                     user_fn(m, r, b * BW + c)});
        for (int n = 0; n < BUF; n++) begin
            video_tvalid[n] = (m != 1) || ($urandom_range(0, 1) == 1);
            drive_line(n);
        end
        block_tready = (m != 1) || ($urandom_range(0, 3) != 0);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk_i);
            check("one_ready", int'($countones(video_tready) <= 1), 1);
            check("err", int'(err_o), int'(err_model));
            if (first_in < 0 && |video_tvalid) first_in = cyc;
            for (int n = 0; n < BUF; n++) begin
                hs[n] = video_tvalid[n] && video_tready[n];
                if (hs[n]) begin
                    in_cnt++;
                    if ((video_tlast[n] != (x[n] == FRX - 1)) ||
                        (video_tuser[n] && !((n == 0) && (x[n] == 0))))
                        err_model = 1'b1;
                end
            end
            if (block_tvalid && first_out < 0) first_out = cyc;
            if (block_tvalid && block_tready) begin
                check("beat_avail", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tdata", int'(block_tdata), int'(e[9:2]));
                    check("tlast", int'(block_tlast), int'(e[1]));
                    check("tuser", int'(block_tuser), int'(e[0]));
                end
                check("sideband", int'({block_tstrb, block_tkeep, block_tid, block_tdest}), 12);
                out_cnt++;
                if (block_tlast) last_cnt++;
                last_out = cyc;
                if (out_cnt == NPIX) done = 1'b1;
            end
            @(posedge clk_i);
            #1;
            for (int n = 0; n < BUF; n++) if (hs[n]) x[n]++;
            if (rst_after > 0 && in_cnt >= rst_after) return;
            for (int n = 0; n < BUF; n++) begin
                if (!(video_tvalid[n] && !hs[n]))
                    video_tvalid[n] = (x[n] < FRX) && ((m != 1) || ($urandom_range(0, 1) == 1));
                drive_line(n);
            end
            block_tready = (m != 1) || ($urandom_range(0, 3) != 0);
        end
        check("timeout", int'(done), 1);
        check("out_beats", out_cnt, NPIX);
        check("in_beats", in_cnt, NPIX);
        check("tlast_count", last_cnt, 2);
        @(negedge clk_i);
        check("err_final", int'(err_o), int'(err_model));
        check("err_scenario", int'(err_o), int'(m >= 2));
        if (m == 0) begin
            check("latency", first_out - first_in, LAT);
            check("span", last_out - first_in + 1, NPIX + LAT);
        end
    endtask

    initial begin
        run_stripe(0, 0);
        run_stripe(1, 0);
        run_stripe(2, 0);
        run_stripe(3, 0);
        run_stripe(0, 37);
        run_stripe(0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
